cdb_arbiter: RTL

//   Shares the single result broadcast bus (CDB) between NREQ execution units (ALU, LSB, MUL).

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_fifo.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common data bus arbiter.
// Source IDs double as requester indices on the arbiter ports.
package cdb_arbiter_pkg;

    localparam int CDB_NREQ  = 3;
    localparam int ROB_TAGW  = 4;
    localparam int CDB_DATAW = 32;
    localparam int CDB_DEPTH = 2;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_LSB = 2'd1;
    localparam logic [1:0] SRC_MUL = 2'd2;

    // (a + b) mod n for a < n, b <= n
    function automatic int wrap_add(int a, int b, int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-requester result queue: DEPTH entries, power-of-two pointers.
// Flush empties the queue and wins over push and pop.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = CDB_DEPTH,
    parameter int W     = ROB_TAGW + CDB_DATAW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered result broadcast bus
// between NREQ execution units, each buffered by a small FIFO.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ  = CDB_NREQ,
    parameter int TAGW  = ROB_TAGW,
    parameter int DATAW = CDB_DATAW,
    parameter int DEPTH = CDB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*TAGW-1:0]  req_tag,
    input  logic [NREQ*DATAW-1:0] req_value,
    output logic [NREQ-1:0]       req_ready,
    output logic                  cdb_valid,
    output logic [TAGW-1:0]       cdb_tag,
    output logic [DATAW-1:0]      cdb_value,
    output logic [1:0]            cdb_src
);

    localparam int W    = TAGW + DATAW;
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] empty, full, push, pop;
    logic [W-1:0]    head [NREQ];
    logic            go, flush, hit;
    logic [PTRW-1:0] win, ptr_q, ptr_d;

    logic             valid_q, valid_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic [DATAW-1:0] value_q, value_d;
    logic [1:0]       src_q, src_d;

    assign go        = rdy & ~rollback;
    assign flush     = rdy & rollback;
    assign req_ready = ~full;
    assign push      = {NREQ{go}} & req_valid & ~full;

    for (genvar g = 0; g < NREQ; g++) begin : g_fifo
        cdb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .flush (flush),
            .din   ({req_tag[g*TAGW +: TAGW], req_value[g*DATAW +: DATAW]}),
            .empty (empty[g]),
            .full  (full[g]),
            .head  (head[g])
        );
    end

    // First non-empty queue at or after the pointer, wrapping.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!hit && !empty[wrap_add(int'(ptr_q), k, NREQ)]) begin
                hit = 1'b1;
                win = PTRW'(wrap_add(int'(ptr_q), k, NREQ));
            end
        end
    end

    always_comb begin
        pop = '0;
        if (go && hit) pop[win] = 1'b1;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        value_d = value_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (rdy) begin
            if (rollback) begin
                valid_d = 1'b0;
                ptr_d   = '0;
            end else if (hit) begin
                valid_d = 1'b1;
                tag_d   = head[win][W-1:DATAW];
                value_d = head[win][DATAW-1:0];
                src_d   = 2'(win);
                ptr_d   = PTRW'(wrap_add(int'(win), 1, NREQ));
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            value_q <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            value_q <= value_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_value = value_q;
    assign cdb_src   = src_q;

endmodule
